// File: rtl/scrambler_lfsr_param.sv
// Parametrised Fibonacci-LFSR scrambler/descrambler with a seed port and an output FIFO.
// Optional macro SCRAMBLER_BYPASS_EN adds a 'bypass' input that passes words through unscrambled.
module scrambler_lfsr_param #(
  parameter int                 DATA_W     = 4,
  parameter int                 LFSR_W     = 7,
  parameter logic [LFSR_W-1:0]  TAPS       = 7'b1001000,
  parameter int                 MODE       = 0,
  parameter int                 FIFO_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
`ifdef SCRAMBLER_BYPASS_EN
  input  logic              bypass,
`endif
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_en,
  output logic              in_rdy,
  input  logic [LFSR_W-1:0] seed_data,
  input  logic              seed_en,
  output logic              seed_rdy,
  input  logic              out_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_rdy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic {S_UNSEEDED, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [AW-1:0]       rdPtr_q, wrPtr_q;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   outData_q;
  logic                inRdy_q, inRdy_d;
  logic                seedRdy_q;

  logic                inFire, outFire, seedFire, bypassActive;
  logic [LFSR_W-1:0]   lfsrStep, seedValue;
  logic [DATA_W-1:0]   scrWord, procWord;
  logic                bitD, bitFb, bitO;
  logic [AW-1:0]       rdNext;

`ifdef SCRAMBLER_BYPASS_EN
  assign bypassActive = bypass;
`else
  assign bypassActive = 1'b0;
`endif

  assign inFire   = in_en & inRdy_q;
  assign outFire  = out_en & out_rdy;
  assign seedFire = seed_en & seedRdy_q;
  assign rdNext   = rdPtr_q + AW'(1);

  // All DATA_W bit steps unrolled; the MSB of the word is the first bit on the line.
  always_comb begin
    lfsrStep = lfsr_q;
    scrWord  = '0;
    bitD     = 1'b0;
    bitFb    = 1'b0;
    bitO     = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      bitD       = in_data[i];
      bitFb      = ^(lfsrStep & TAPS);
      bitO       = bitD ^ bitFb;
      scrWord[i] = bitO;
      case (MODE)
        0:       lfsrStep = {lfsrStep[LFSR_W-2:0], bitFb};
        1:       lfsrStep = {lfsrStep[LFSR_W-2:0], bitO};
        default: lfsrStep = {lfsrStep[LFSR_W-2:0], bitD};
      endcase
    end
  end

  always_comb begin
    procWord  = bypassActive ? in_data : scrWord;
    seedValue = (MODE == 0 && seed_data == '0) ? '1 : seed_data;
    lfsr_d    = lfsr_q;
    if (seedFire)
      lfsr_d = seedValue;
    else if (inFire && !bypassActive)
      lfsr_d = lfsrStep;
    count_d = count_q;
    case ({inFire, outFire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    state_d = seedFire ? S_RUN : state_q;
    inRdy_d = (state_d == S_RUN) && (count_d != FULL_CNT);
  end

  // Control FSM, LFSR and FIFO share one register block; the head word is kept registered.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_UNSEEDED;
      lfsr_q    <= '1;
      count_q   <= '0;
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
      outData_q <= '0;
      inRdy_q   <= 1'b0;
      seedRdy_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      count_q   <= count_d;
      inRdy_q   <= inRdy_d;
      seedRdy_q <= 1'b1;
      if (inFire) begin
        mem_q[wrPtr_q] <= procWord;
        wrPtr_q        <= wrPtr_q + AW'(1);
      end
      if (outFire) begin
        rdPtr_q <= rdNext;
        if (count_q > CW'(1))
          outData_q <= mem_q[rdNext];
        else if (inFire)
          outData_q <= procWord;
      end else if (inFire && count_q == '0) begin
        outData_q <= procWord;
      end
    end
  end

  assign in_rdy   = inRdy_q;
  assign seed_rdy = seedRdy_q;
  assign out_rdy  = (count_q != '0);
  assign out_data = outData_q;

endmodule
